// File: rtl/membus_arbiter.sv
// Arbitrates the single DataMem port between the MEM stage (fixed priority) and a DMA engine.
// A saturating starvation counter forces one DMA access through after MAX_WAIT blocked cycles.
module membus_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  // MEM-stage side
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // DMA side
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  // DataMem side
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gen_bad_max_wait
    $error("membus_arbiter: MAX_WAIT must be in 1..15");
  end

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OwnIdle = 2'b00,
    OwnCpu  = 2'b01,
    OwnDma  = 2'b10
  } owner_e;

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  owner_e      owner_q, owner_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        dma_rvalid_q, dma_rvalid_d;

  logic cpu_act;
  logic wait_full;
  logic dma_grant;
  logic cpu_grant;

  // Grant decision and port mux: purely combinational, no added latency on the CPU path.
  always_comb begin
    cpu_act   = cpu_rd | cpu_wr;
    wait_full = (wait_cnt_q == MaxWaitCnt);
    dma_grant = Reset_n & dma_req & (~cpu_act | wait_full);
    cpu_grant = Reset_n & cpu_act & ~dma_grant;

    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_grant) begin
      mem_rd    = ~dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_grant) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end

    // Zero when not a granted CPU load so the result can be ORed onto a shared bus.
    cpu_rdata  = (cpu_grant & cpu_rd) ? mem_rdata : '0;
    cpu_stall  = Reset_n & cpu_act & dma_grant;
    dma_ack    = dma_grant;
    dma_rdata  = dma_rdata_q;
    dma_rvalid = dma_rvalid_q;
  end

  // Next-state logic for the starvation counter, owner tracker and DMA read return.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    owner_d      = OwnIdle;
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;

    if (!dma_req || dma_grant) begin
      wait_cnt_d = 4'd0;
    end else if (!wait_full) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (dma_grant) begin
      owner_d = OwnDma;
    end else if (cpu_grant) begin
      owner_d = OwnCpu;
    end

    if (dma_grant && !dma_wr) begin
      dma_rdata_d  = mem_rdata;
      dma_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      wait_cnt_q   <= 4'd0;
      owner_q      <= OwnIdle;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // Invariants: counter saturates, owner stays one of its three encodings.
  a_wait_sat: assert property (@(posedge CLK) disable iff (!Reset_n)
    wait_cnt_q <= MaxWaitCnt);
  a_owner_legal: assert property (@(posedge CLK) disable iff (!Reset_n)
    owner_q inside {OwnIdle, OwnCpu, OwnDma});

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: a reference model pushes expected port values to a
// scoreboard queue as each step is driven; they are popped and compared mid-cycle.
module tb_membus_arbiter;

  localparam int unsigned MaxWait = 4;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, dma_rvalid;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  membus_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Environment DataMem, driven by the DUT's memory port.
  logic [31:0] env_mem [0:255];
  assign mem_rdata = env_mem[mem_addr[9:2]];
  always @(posedge CLK) begin
    if (mem_wr) env_mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic [3:0]  wait_cnt;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];

  // Reference model state
  logic [31:0] ref_mem [0:255];
  logic [3:0]  m_wait;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    dma_req = req; dma_wr = wr; dma_addr = addr; dma_wdata = wdata;
  endtask

  // One clock cycle: predict, push, sample at negedge, pop/compare, advance model.
  task automatic step(input string tag);
    exp_t e, o;
    logic cact, dg, cg;
    string t;
    cact = cpu_rd | cpu_wr;
    dg   = Reset_n & dma_req & (!cact | (m_wait == 4'(MaxWait)));
    cg   = Reset_n & cact & !dg;
    e.mem_rd     = dg ? !dma_wr : (cg ? cpu_rd : 1'b0);
    e.mem_wr     = dg ? dma_wr : (cg ? cpu_wr : 1'b0);
    e.mem_addr   = dg ? dma_addr : (cg ? cpu_addr : 32'h0);
    e.mem_wdata  = dg ? dma_wdata : (cg ? cpu_wdata : 32'h0);
    e.cpu_rdata  = (cg && cpu_rd) ? ref_mem[cpu_addr[9:2]] : 32'h0;
    e.cpu_stall  = Reset_n & cact & dg;
    e.dma_ack    = dg;
    e.dma_rdata  = m_rdata;
    e.dma_rvalid = m_rvalid;
    e.wait_cnt   = m_wait;
    sb_q.push_back(e);
    tag_q.push_back(tag);

    @(negedge CLK);
    o = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "mem_rd",     {31'b0, mem_rd},     {31'b0, o.mem_rd});
    chk(t, "mem_wr",     {31'b0, mem_wr},     {31'b0, o.mem_wr});
    chk(t, "mem_addr",   mem_addr,            o.mem_addr);
    chk(t, "mem_wdata",  mem_wdata,           o.mem_wdata);
    chk(t, "cpu_rdata",  cpu_rdata,           o.cpu_rdata);
    chk(t, "cpu_stall",  {31'b0, cpu_stall},  {31'b0, o.cpu_stall});
    chk(t, "dma_ack",    {31'b0, dma_ack},    {31'b0, o.dma_ack});
    chk(t, "dma_rdata",  dma_rdata,           o.dma_rdata);
    chk(t, "dma_rvalid", {31'b0, dma_rvalid}, {31'b0, o.dma_rvalid});
    chk(t, "wait_cnt",   {28'b0, dut.wait_cnt_q}, {28'b0, o.wait_cnt});

    if (!Reset_n) begin
      m_wait = 4'd0; m_rdata = 32'h0; m_rvalid = 1'b0;
    end else begin
      m_rvalid = dg & !dma_wr;
      if (dg && !dma_wr) m_rdata = ref_mem[dma_addr[9:2]];
      if (!dma_req || dg) m_wait = 4'd0;
      else if (m_wait != 4'(MaxWait)) m_wait = m_wait + 4'd1;
      if (dg && dma_wr) ref_mem[dma_addr[9:2]] = dma_wdata;
      if (cg && cpu_wr) ref_mem[cpu_addr[9:2]] = cpu_wdata;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m_wait = 4'd0; m_rdata = 32'h0; m_rvalid = 1'b0;

    // Reset with both requesters active: everything held at zero.
    Reset_n = 1'b0;
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dma(1'b1, 1'b1, 32'h80, 32'h1234_5678);
    step("rst0");
    step("rst1");

    // Starvation: CPU first, forced DMA write in cycle 5, then 4 CPU cycles, forced again.
    Reset_n = 1'b1;
    for (int i = 0; i < 11; i++) step($sformatf("starve%0d", i));
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step("starve_drop");

    // CPU only: store then load.
    set_cpu(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step("cpu_wr");
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    step("cpu_rd");
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);

    // DMA read on an idle bus, then read data returns one cycle later.
    set_dma(1'b1, 1'b0, 32'h40, 32'h0);
    step("dma_rd");
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step("dma_rvalid");
    step("dma_hold");

    // Back-to-back DMA reads with the CPU idle.
    set_dma(1'b1, 1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 3; i++) step($sformatf("b2b%0d", i));
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step("b2b_tail");

    // Mid-operation reset with wait_cnt at 3.
    set_cpu(1'b1, 1'b0, 32'h80, 32'h0);
    set_dma(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) step($sformatf("pre_rst%0d", i));
    Reset_n = 1'b0;
    step("mid_rst");
    Reset_n = 1'b1;
    for (int i = 0; i < 2; i++) step($sformatf("post_rst%0d", i));
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
